// File: rtl/integrator_sequencer.sv
// integrator_sequencer: ce rate divider, run/drain sequencing and
// fault/saturation monitoring around one sampled datapath.
module integrator_sequencer #(
  parameter int DW      = 24,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 4,
  parameter int LAT_MAX = 8,
  parameter int SAT_LIM = 4194304
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             clr_flags,
  input  logic [DW-1:0]    sig_src,
  output logic             dp_ce_in,
  output logic [DW-1:0]    dp_sig_in,
  input  logic             dp_ce_out,
  input  logic [DW-1:0]    dp_sig_out,
  output logic [DW-1:0]    result,
  output logic             result_vld,
  output logic [1:0]       state,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_spur,
  output logic             sat_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } st_t;

  localparam int LAT_W = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic signed [DW-1:0] SAT_P = DW'(SAT_LIM);
  localparam logic signed [DW-1:0] SAT_N = DW'(-SAT_LIM);

  st_t st_q, st_d;
  logic [DIV_W-1:0] div_cnt, div_lat;
  logic [CNT_W-1:0] pend, pend_d;
  logic [LAT_W-1:0] lat_cnt;
  logic wrap, issue, accept, spur;
  logic lat_hit, sat_hit;

  assign wrap    = (st_q == RUN) && (div_cnt == div_lat);
  assign accept  = dp_ce_out && (pend != '0);
  assign spur    = dp_ce_out && (pend == '0);
  assign lat_hit = (pend != '0) && !dp_ce_out
                && (lat_cnt == LAT_W'(LAT_MAX - 1));
  assign issue   = wrap && !cmd_stop
                && (pend != PEND_MAX) && !lat_hit;
  assign sat_hit = accept
                && (($signed(dp_sig_out) >= SAT_P)
                 || ($signed(dp_sig_out) <= SAT_N));

  assign state = st_q;
  assign busy  = (st_q != IDLE) || (pend != '0);

  always_comb begin
    pend_d = pend;
    unique case (1'b1)
      lat_hit:          pend_d = '0;
      issue && !accept: pend_d = pend + 1'b1;
      accept && !issue: pend_d = pend - 1'b1;
      default:          pend_d = pend;
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (cmd_start && !cmd_stop) st_d = RUN;
      RUN:     if (cmd_stop) st_d = DRAIN;
      DRAIN:   if (pend_d == '0) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (lat_hit) st_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // div_lat tracks cfg_div while idle, so RUN entry sees a fresh period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (st_q == IDLE) begin
      div_cnt <= '0;
      div_lat <= cfg_div;
    end else if (issue) begin
      div_cnt <= '0;
      div_lat <= cfg_div;
    end else if (st_q == RUN && !wrap) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      lat_cnt <= '0;
    end else begin
      pend <= pend_d;
      if (pend == '0 || dp_ce_out || lat_hit)
        lat_cnt <= '0;
      else
        lat_cnt <= lat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_ce_in  <= 1'b0;
      dp_sig_in <= '0;
    end else begin
      dp_ce_in <= issue;
      if (issue) dp_sig_in <= sig_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      result_vld <= 1'b0;
    end else begin
      result_vld <= accept;
      if (accept) result <= dp_sig_out;
    end
  end

  // a set event in the same cycle as clr_flags keeps the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
      err_spur    <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      err_timeout <= lat_hit | (err_timeout & ~clr_flags);
      err_spur    <= spur    | (err_spur    & ~clr_flags);
      sat_flag    <= sat_hit | (sat_flag    & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_integrator_sequencer.sv
// tb_integrator_sequencer: randomized loopback runs scored against a
// cycle-count model, plus directed reset, fault and saturation cases.
`timescale 1ns/1ps
module tb_integrator_sequencer;

  localparam int DW  = 24;
  localparam int SAT = 4194304;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   cfg_div = '0;
  logic          cmd_start = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          clr_flags = 1'b0;
  logic [DW-1:0] sig_src = '0;
  logic          dp_ce_in;
  logic [DW-1:0] dp_sig_in;
  logic          dp_ce_out;
  logic [DW-1:0] dp_sig_out;
  logic [DW-1:0] result;
  logic          result_vld;
  logic [1:0]    state;
  logic          busy, err_timeout, err_spur, sat_flag;

  logic          loop_en = 1'b0;
  logic          man_ce = 1'b0;
  logic [DW-1:0] man_sig = '0;
  int            dly = 3;
  logic          pipe_ce [8];
  logic [DW-1:0] pipe_sig [8];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] val;
  } exp_t;

  bit            mon_en = 1'b0;
  bit            m_run = 1'b0;
  int            m_s, m_stop, m_div;
  int            m_pend = 0;
  logic [DW-1:0] src_hist [64];
  logic [DW-1:0] infl_q [$];
  exp_t          exp_q [$];

  integrator_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_div     (cfg_div),
    .cmd_start   (cmd_start),
    .cmd_stop    (cmd_stop),
    .clr_flags   (clr_flags),
    .sig_src     (sig_src),
    .dp_ce_in    (dp_ce_in),
    .dp_sig_in   (dp_sig_in),
    .dp_ce_out   (dp_ce_out),
    .dp_sig_out  (dp_sig_out),
    .result      (result),
    .result_vld  (result_vld),
    .state       (state),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_spur    (err_spur),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe_ce[0]  <= dp_ce_in;
    pipe_sig[0] <= dp_sig_in;
    for (int i = 1; i < 8; i++) begin
      pipe_ce[i]  <= pipe_ce[i-1];
      pipe_sig[i] <= pipe_sig[i-1];
    end
  end

  // fake datapath: negates the sample after dly cycles
  assign dp_ce_out  = loop_en ? pipe_ce[dly-1] : man_ce;
  assign dp_sig_out = loop_en ? DW'(0) - pipe_sig[dly-1] : man_sig;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_src(bit fixed);
    step();
    if (fixed) sig_src = DW'(419430);
    else sig_src = DW'($urandom_range(0, 2*SAT-2) - (SAT-1));
    src_hist[(cyc+1) % 64] = sig_src;
  endtask

  // scoreboard monitor
  logic          mon_ce, mon_vld;
  logic [1:0]    mon_st;
  logic [DW-1:0] mon_v;
  exp_t          mon_e;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      mon_ce = m_run && cyc > m_s && cyc < m_stop
            && ((cyc - m_s) % (m_div + 1)) == 0;
      if (mon_ce) begin
        m_pend++;
        infl_q.push_back(src_hist[cyc % 64]);
      end
      chk("ce_timing", dp_ce_in, mon_ce);
      if (mon_ce) chk("ce_sample", dp_sig_in, src_hist[cyc % 64]);
      if (!m_run || cyc < m_s)  mon_st = 2'b00;
      else if (cyc < m_stop)    mon_st = 2'b01;
      else if (cyc == m_stop)   mon_st = 2'b10;
      else mon_st = (m_pend != 0) ? 2'b10 : 2'b00;
      chk("state", state, mon_st);
      chk("busy", busy, (mon_st != 2'b00) || (m_pend != 0));
      mon_vld = 1'b0;
      if (exp_q.size() > 0)
        if (exp_q[0].cyc == cyc) mon_vld = 1'b1;
      chk("result_vld", result_vld, mon_vld);
      if (mon_vld) begin
        mon_e = exp_q.pop_front();
        if (result_vld) chk("result", result, mon_e.val);
      end
      if (dp_ce_out && m_pend > 0) begin
        mon_v = DW'(0) - infl_q.pop_front();
        exp_q.push_back('{cyc + 1, mon_v});
        m_pend--;
      end
    end
  end

  task automatic run_loop(int div, int d, bit fixed, int len);
    int n;
    dly     = d;
    cfg_div = div[15:0];
    loop_en = 1'b1;
    m_div   = div;
    m_stop  = 1 << 30;
    m_s     = cyc + 1;
    m_run   = 1'b1;
    mon_en  = 1'b1;
    cmd_start = 1'b1;
    step_src(fixed);
    for (int i = 0; i < len; i++) begin
      cmd_start = ($urandom_range(0, 9) == 0);
      step_src(fixed);
    end
    cmd_start = 1'b0;
    cmd_stop  = 1'b1;
    m_stop    = cyc + 1;
    step_src(fixed);
    cmd_stop = 1'b0;
    n = 0;
    while (state != 2'b00 && n < 60) begin
      step_src(fixed);
      n++;
    end
    chk("drain_done", state, 2'b00);
    repeat (6) step_src(fixed);
    chk("sb_empty", exp_q.size(), 0);
    mon_en  = 1'b0;
    m_run   = 1'b0;
    loop_en = 1'b0;
    exp_q.delete();
    infl_q.delete();
    m_pend = 0;
  endtask

  task automatic one_return(logic [DW-1:0] v, bit clr);
    cfg_div   = '0;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    step();
    cmd_stop  = 1'b1;
    man_ce    = 1'b1;
    man_sig   = v;
    clr_flags = clr;
    step();
    cmd_stop  = 1'b0;
    man_ce    = 1'b0;
    clr_flags = 1'b0;
    chk("ret_vld", result_vld, 1'b1);
    chk("ret_value", result, v);
    step();
    chk("ret_idle", state, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, tce;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("init_state", {state, busy, dp_ce_in}, 0);

    man_ce = 1'b1;
    step();
    man_ce = 1'b0;
    chk("spur_idle", err_spur, 1'b1);
    chk("spur_no_vld", result_vld, 1'b0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("spur_clr", err_spur, 1'b0);

    cfg_div   = 16'd4;
    sig_src   = DW'(123);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    t0 = cyc;
    n = 0;
    while (!dp_ce_in && n < 20) begin step(); n++; end
    chk("first_ce_gap", cyc - t0, 5);
    chk("first_ce_sample", dp_sig_in, DW'(123));
    tce = cyc;
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    chk("drain_state", state, 2'b10);
    n = 0;
    while (!err_timeout && n < 30) begin step(); n++; end
    chk("timeout_lat", cyc - tce, 8);
    chk("timeout_idle", {state, busy}, 0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("timeout_clr", err_timeout, 1'b0);

    cfg_div   = '0;
    cmd_start = 1'b1;
    cmd_stop  = 1'b1;
    step();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    chk("start_stop_idle", {state, busy}, 0);
    step();
    chk("start_stop_no_ce", dp_ce_in, 1'b0);

    one_return(DW'(-SAT), 1'b0);
    chk("sat_neg", sat_flag, 1'b1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("sat_clr", sat_flag, 1'b0);
    one_return(DW'(SAT - 1), 1'b0);
    chk("sat_below_pos", sat_flag, 1'b0);
    one_return(DW'(-(SAT - 1)), 1'b0);
    chk("sat_below_neg", sat_flag, 1'b0);
    one_return(DW'(SAT), 1'b1);
    chk("sat_set_wins", sat_flag, 1'b1);

    sig_src   = DW'(777);
    cfg_div   = '0;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    step();
    step();
    chk("pre_rst_run", {state, busy}, {2'b01, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("rst_async", {dp_ce_in, dp_sig_in, result, result_vld,
                      state, busy, err_timeout, err_spur, sat_flag}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    man_ce  = 1'b1;
    man_sig = DW'(55);
    step();
    man_ce = 1'b0;
    chk("spur_after_rst", {err_spur, result_vld}, {1'b1, 1'b0});
    chk("result_kept", result, 0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    repeat (10) step();

    run_loop(4, 3, 1'b1, 30);
    run_loop(0, 4, 1'b0, 20);
    run_loop(0, 1, 1'b0, 15);
    for (int r = 0; r < 4; r++)
      run_loop($urandom_range(0, 5), $urandom_range(1, 4), 1'b0,
               $urandom_range(10, 40));

    chk("flags_clean", {err_timeout, err_spur, sat_flag}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
